data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: byte/half/word loads and stores with programmable wait states.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        misalign_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned LW = AW + 2;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          mis_q, mis_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [LW-1:0] addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          commit_c;
  logic          enter_resp_c;
  logic [LW-1:0] acc_addr_c;
  logic [2:0]    acc_f3_c;
  logic [31:0]   acc_wdata_c;
  logic          acc_wr_c;
  logic [AW-1:0] idx_c;
  logic          is_byte_c, is_half_c, is_word_c;
  logic          mis_c;
  logic [31:0]   word_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   load_c;
  logic [3:0]    be_c;
  logic [31:0]   wlane_c;
  logic          unused_addr_c;

  assign unused_addr_c = ^addr_i[31:LW];

  // With zero wait states the access completes straight from IDLE, so use live inputs there.
  assign acc_addr_c  = (state_q == S_IDLE) ? addr_i[LW-1:0] : addr_q;
  assign acc_f3_c    = (state_q == S_IDLE) ? func3_i : f3_q;
  assign acc_wdata_c = (state_q == S_IDLE) ? wdata_i : wdata_q;
  assign acc_wr_c    = (state_q == S_IDLE) ? mem_write_i : wr_q;

  assign idx_c     = acc_addr_c[LW-1:2];
  assign is_byte_c = (acc_f3_c[1:0] == 2'b00);
  assign is_half_c = (acc_f3_c[1:0] == 2'b01);
  assign is_word_c = !is_byte_c && !is_half_c;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_c = (is_half_c && acc_addr_c[0]) || (is_word_c && (acc_addr_c[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  assign word_c = mem_q[idx_c];
  assign half_c = acc_addr_c[1] ? word_c[31:16] : word_c[15:0];

  always_comb begin
    byte_c = word_c[7:0];
    case (acc_addr_c[1:0])
      2'd1:    byte_c = word_c[15:8];
      2'd2:    byte_c = word_c[23:16];
      2'd3:    byte_c = word_c[31:24];
      default: byte_c = word_c[7:0];
    endcase
  end

  always_comb begin
    load_c = word_c;
    case (acc_f3_c)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = word_c;
    endcase
  end

  // Byte-lane enables and replicated store data for the selected size.
  always_comb begin
    be_c    = 4'b1111;
    wlane_c = acc_wdata_c;
    if (is_byte_c) begin
      be_c    = 4'(4'b0001 << acc_addr_c[1:0]);
      wlane_c = {4{acc_wdata_c[7:0]}};
    end else if (is_half_c) begin
      be_c    = acc_addr_c[1] ? 4'b1100 : 4'b0011;
      wlane_c = {2{acc_wdata_c[15:0]}};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    ready_d      = 1'b0;
    mis_d        = 1'b0;
    rdata_d      = rdata_q;
    addr_d       = addr_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    enter_resp_c = 1'b0;
    commit_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read_i || mem_write_i) begin
          addr_d  = addr_i[LW-1:0];
          f3_d    = func3_i;
          wdata_d = wdata_i;
          wr_d    = mem_write_i;
          busy_d  = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d      = S_RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = S_RESP;
          enter_resp_c = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    if (enter_resp_c) begin
      ready_d  = 1'b1;
      mis_d    = mis_c;
      commit_c = acc_wr_c && !mis_c;
      if (!acc_wr_c) begin
        rdata_d = mis_c ? 32'd0 : load_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // Storage array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (commit_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
      end
    end
  end

  assign rdata_o    = rdata_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign misalign_o = mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a byte-level reference model.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk, rst;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  func3_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        ready_o, busy_o, misalign_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .ready_o(ready_o), .busy_o(busy_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: size from func3, word index modulo depth, lane from low address bits.
  task automatic model_step(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic mis);
    int unsigned idx;
    int unsigned sz;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    idx = (a / 4) % DEPTH;
    sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    mis = ALIGN && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
    w   = mem_m[idx];
    if (wr) begin
      if (!mis) begin
        if (sz == 1)      w[8*a[1:0] +: 8] = wd[7:0];
        else if (sz == 2) w[16*a[1] +: 16] = wd[15:0];
        else              w = wd;
        mem_m[idx] = w;
      end
    end else if (mis) begin
      last_rd = 32'd0;
    end else begin
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      case (f3)
        3'd0:    last_rd = 32'($signed(b));
        3'd4:    last_rd = 32'(b);
        3'd1:    last_rd = 32'($signed(h));
        3'd5:    last_rd = 32'(h);
        default: last_rd = w;
      endcase
    end
  endtask

  // Issue one request from an IDLE negedge and check the whole response window.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    logic mis;
    model_step(wr, f3, a, wd, mis);
    mem_read_i = rd; mem_write_i = wr; func3_i = f3; addr_i = a; wdata_i = wd;
    @(posedge clk);
    #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    for (int k = 1; k <= int'(WAITC) + 1; k++) begin
      @(negedge clk);
      check_eq("busy_inflight", 32'(busy_o), 32'd1);
      check_eq("ready_timing", 32'(ready_o), 32'(k == int'(WAITC) + 1));
    end
    check_eq("misalign", 32'(misalign_o), 32'(mis));
    check_eq("rdata", rdata_o, last_rd);
    @(negedge clk);
    check_eq("busy_idle", 32'(busy_o), 32'd0);
    check_eq("ready_pulse", 32'(ready_o), 32'd0);
    check_eq("rdata_hold", rdata_o, last_rd);
  endtask

  initial begin
    logic [2:0]  f3_tab [8];
    int          prev, pulses, r;
    logic [31:0] a;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    last_rd = 32'd0;
    rst = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0;
    func3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_ready", 32'(ready_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_misalign", 32'(misalign_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom());

    access(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    check_eq("lw_deadbeef", rdata_o, 32'hDEADBEEF);

    access(1'b0, 1'b1, 3'd2, 32'h10, 32'h11223344);
    access(1'b0, 1'b1, 3'd0, 32'h13, 32'hABCDEF80);
    access(1'b1, 1'b0, 3'd0, 32'h13, 32'h0);
    check_eq("lb_13", rdata_o, 32'hFFFFFF80);
    access(1'b1, 1'b0, 3'd4, 32'h13, 32'h0);
    check_eq("lbu_13", rdata_o, 32'h00000080);
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    check_eq("lw_10_merged", rdata_o, 32'h80223344);

    access(1'b0, 1'b1, 3'd1, 32'h22, 32'h1234BEEF);
    access(1'b1, 1'b0, 3'd1, 32'h22, 32'h0);
    check_eq("lh_22", rdata_o, 32'hFFFFBEEF);
    access(1'b1, 1'b0, 3'd5, 32'h22, 32'h0);
    check_eq("lhu_22", rdata_o, 32'h0000BEEF);

    // Held read: one pulse every WAITC+2 cycles, nothing accepted while busy.
    mem_read_i = 1'b1; func3_i = 3'd2; addr_i = 32'h10;
    prev = 0; pulses = 0;
    for (int k = 1; k <= 4 * (int'(WAITC) + 2); k++) begin
      @(negedge clk);
      if (ready_o) begin
        pulses++;
        if (prev == 0) check_eq("hold_first", 32'(k), 32'(WAITC + 1));
        else           check_eq("hold_spacing", 32'(k - prev), 32'(WAITC + 2));
        prev = k;
      end
    end
    mem_read_i = 1'b0;
    check_eq("hold_pulses", 32'(pulses), 32'd4);
    last_rd = mem_m[4];
    check_eq("hold_rdata", rdata_o, last_rd);

    // Reset during WAIT abandons the store.
    access(1'b0, 1'b1, 3'd2, 32'h4, 32'h12345678);
    mem_write_i = 1'b1; func3_i = 3'd2; addr_i = 32'h4; wdata_i = 32'h55;
    @(posedge clk);
    #1;
    mem_write_i = 1'b0;
    @(negedge clk);
    check_eq("wait_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstwait_busy", 32'(busy_o), 32'd0);
    check_eq("rstwait_ready", 32'(ready_o), 32'd0);
    check_eq("rstwait_rdata", rdata_o, 32'd0);
    last_rd = 32'd0;
    access(1'b1, 1'b0, 3'd2, 32'h4, 32'h0);
    check_eq("lw_after_rst", rdata_o, 32'h12345678);

    // Misaligned word store.
    access(1'b0, 1'b1, 3'd2, 32'h4, 32'hCAFEF00D);
    access(1'b0, 1'b1, 3'd2, 32'h6, 32'h11111111);
    access(1'b1, 1'b0, 3'd2, 32'h4, 32'h0);
    check_eq("lw_4_after_sw6", rdata_o, ALIGN ? 32'hCAFEF00D : 32'h11111111);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 3));
      a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      access(r != 2, r >= 2, f3_tab[$urandom_range(0, 7)], a, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
